// File: rtl/array_divider_pipeline_if.sv
// Operand/result bus for the pipelined divider.
// The master drives operands and the slave returns the quotient and remainder.
interface array_divider_pipeline_if #(
  parameter int width = 32
);
  logic             in_valid;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             out_valid;
  logic [width-1:0] q;
  logic [width-1:0] r;

  modport master (
    output in_valid, a, b,
    input  out_valid, q, r
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, q, r
  );
endinterface

// File: rtl/array_divider_pipeline.sv
// Fully pipelined restoring array divider. Each stage resolves one quotient
// bit, MSB first. A result appears width cycles after its operands.
module array_divider_pipeline #(
  parameter int width = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  array_divider_pipeline_if.slave  bus
);

  genvar gi;

  generate
    for (gi = 0; gi < width; gi++) begin : g_stage
      logic [width-1:0] rem_in;
      logic [width-1:0] dq_in;
      logic [width-1:0] b_in;
      logic             vld_in;

      logic [width-1:0] partial;
      logic [width:0]   diff;
      logic             qbit;

      logic [width-1:0] rem_d, rem_q;
      logic [width-1:0] dq_d, dq_q;
      logic [width-1:0] b_d, b_q;
      logic             vld_d, vld_q;

      // The shifted-out remainder MSB is always zero: before stage gi the
      // remainder never exceeds the gi dividend bits already consumed.
      logic unused_rem_msb;
      assign unused_rem_msb = rem_in[width-1];

      if (gi == 0) begin : g_head
        assign rem_in = '0;
        assign dq_in  = bus.a;
        assign b_in   = bus.b;
        assign vld_in = bus.in_valid;
      end else begin : g_link
        assign rem_in = g_stage[gi-1].rem_q;
        assign dq_in  = g_stage[gi-1].dq_q;
        assign b_in   = g_stage[gi-1].b_q;
        assign vld_in = g_stage[gi-1].vld_q;
      end

      // dq holds the unconsumed dividend bits on the left and the quotient
      // bits on the right; after the last stage it is the quotient.
      always_comb begin
        partial = {rem_in[width-2:0], dq_in[width-1]};
        diff    = {1'b0, partial} - {1'b0, b_in};
        qbit    = ~diff[width];
        rem_d   = qbit ? diff[width-1:0] : partial;
        dq_d    = {dq_in[width-2:0], qbit};
        b_d     = b_in;
        vld_d   = vld_in;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rem_q <= '0;
          dq_q  <= '0;
          b_q   <= '0;
          vld_q <= 1'b0;
        end else begin
          rem_q <= rem_d;
          dq_q  <= dq_d;
          b_q   <= b_d;
          vld_q <= vld_d;
        end
      end
    end
  endgenerate

  // The divisor leaving the final stage has no consumer.
  logic unused_tail_b;
  assign unused_tail_b = ^g_stage[width-1].b_q;

  assign bus.out_valid = g_stage[width-1].vld_q;
  assign bus.q         = g_stage[width-1].dq_q;
  assign bus.r         = g_stage[width-1].rem_q;

endmodule

// File: tb/tb_array_divider_pipeline.sv
// Directed and streamed checks of the pipelined divider at width 32 and 8.
// A scoreboard per instance tracks expected results and their due cycle.
module tb_array_divider_pipeline;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   pulses32 = 0;
  int   pulses8  = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          due;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  logic [31:0] xs_state = 32'd1;

  logic [31:0] ca [9] = '{32'd100, 32'd12345, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                          32'd1000000, 32'd0, 32'd0, 32'h80000000};
  logic [31:0] cb [9] = '{32'd7, 32'd0, 32'd9, 32'd1, 32'hFFFFFFFF,
                          32'd1000, 32'd5, 32'd0, 32'd3};
  logic [31:0] cq [9] = '{32'd14, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd1,
                          32'd1000, 32'd0, 32'hFFFFFFFF, 32'h2AAAAAAA};
  logic [31:0] cr [9] = '{32'd2, 32'd12345, 32'd5, 32'd0, 32'd0,
                          32'd0, 32'd0, 32'd0, 32'd2};

  logic [31:0] bq_a [5] = '{32'd200, 32'd17, 32'd255, 32'd1, 32'd99};
  logic [31:0] bq_b [5] = '{32'd3, 32'd4, 32'd16, 32'd2, 32'd11};
  logic [31:0] bq_q [5] = '{32'd66, 32'd4, 32'd15, 32'd0, 32'd9};
  logic [31:0] bq_r [5] = '{32'd2, 32'd1, 32'd15, 32'd1, 32'd0};

  logic [31:0] rp_a [3] = '{32'd81, 32'd82, 32'd1000};
  logic [31:0] rp_b [3] = '{32'd9, 32'd9, 32'd7};
  logic [31:0] rp_q [3] = '{32'd9, 32'd9, 32'd142};
  logic [31:0] rp_r [3] = '{32'd0, 32'd1, 32'd6};

  array_divider_pipeline_if #(.width(32)) bus32 ();
  array_divider_pipeline_if #(.width(8))  bus8 ();

  array_divider_pipeline #(.width(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  array_divider_pipeline #(.width(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] xs_next();
    xs_state = xs_state ^ (xs_state << 13);
    xs_state = xs_state ^ (xs_state >> 17);
    xs_state = xs_state ^ (xs_state << 5);
    return xs_state;
  endfunction

  task automatic drive32(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eq, input logic [31:0] er);
    @(negedge clk); #1;
    reset          = 1'b0;
    bus32.in_valid = 1'b1;
    bus32.a        = av;
    bus32.b        = bv;
    bus8.in_valid  = 1'b0;
    bus8.a         = 'x;
    bus8.b         = 'x;
    sb32.push_back('{64'(eq), 64'(er), cyc + 32});
  endtask

  task automatic drive8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eq, input logic [7:0] er);
    @(negedge clk); #1;
    reset          = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.a         = av;
    bus8.b         = bv;
    bus32.in_valid = 1'b0;
    bus32.a        = 'x;
    bus32.b        = 'x;
    sb8.push_back('{64'(eq), 64'(er), cyc + 8});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      bus32.in_valid = 1'b0;
      bus32.a        = 'x;
      bus32.b        = 'x;
      bus8.in_valid  = 1'b0;
      bus8.a         = 'x;
      bus8.b         = 'x;
    end
  endtask

  // Reset for one edge, optionally with a pair offered on that same edge.
  task automatic do_reset(input logic with_valid, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk); #1;
    reset          = 1'b1;
    bus32.in_valid = with_valid;
    bus32.a        = av;
    bus32.b        = bv;
    bus8.in_valid  = 1'b0;
    sb32.delete();
    sb8.delete();
    @(posedge clk); #1;
    reset          = 1'b0;
    bus32.in_valid = 1'b0;
    bus32.a        = 'x;
    bus32.b        = 'x;
    chk("rst_ov32", 64'(bus32.out_valid), 64'd0);
    chk("rst_q32",  64'(bus32.q), 64'd0);
    chk("rst_r32",  64'(bus32.r), 64'd0);
    chk("rst_ov8",  64'(bus8.out_valid), 64'd0);
    chk("rst_r8",   64'(bus8.r), 64'd0);
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 100 && (sb32.size() != 0 || sb8.size() != 0); i++) begin
      @(negedge clk); #1;
    end
    chk("drain", 64'(sb32.size() + sb8.size()), 64'd0);
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    chk("ovx32", 64'($isunknown(bus32.out_valid)), 64'd0);
    if (bus32.out_valid === 1'b1) begin
      pulses32++;
      if (sb32.size() == 0) begin
        chk("spur32", 64'(bus32.out_valid), 64'd0);
      end else begin
        e = sb32.pop_front();
        $display("w32 cycle=%0d q=%0h r=%0h", cyc, bus32.q, bus32.r);
        chk("lat32", 64'(cyc), 64'(e.due));
        chk("q32", 64'(bus32.q), e.q);
        chk("r32", 64'(bus32.r), e.r);
      end
    end else if (sb32.size() != 0 && sb32[0].due <= cyc) begin
      chk("miss32", 64'(bus32.out_valid), 64'd1);
      void'(sb32.pop_front());
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    chk("ovx8", 64'($isunknown(bus8.out_valid)), 64'd0);
    if (bus8.out_valid === 1'b1) begin
      pulses8++;
      if (sb8.size() == 0) begin
        chk("spur8", 64'(bus8.out_valid), 64'd0);
      end else begin
        e = sb8.pop_front();
        chk("lat8", 64'(cyc), 64'(e.due));
        chk("q8", 64'(bus8.q), e.q);
        chk("r8", 64'(bus8.r), e.r);
      end
    end else if (sb8.size() != 0 && sb8[0].due <= cyc) begin
      chk("miss8", 64'(bus8.out_valid), 64'd1);
      void'(sb8.pop_front());
    end
  end

  initial begin
    int p;
    logic [31:0] av, bv;
    logic [7:0]  a8, b8;

    bus32.in_valid = 1'b0;
    bus32.a        = '0;
    bus32.b        = '0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;

    do_reset(1'b0, 32'd0, 32'd0);

    // Single pair, then idle: exactly one pulse.
    p = pulses32;
    drive32(32'd100, 32'd7, 32'd14, 32'd2);
    drain();
    chk("basic_pulses", 64'(pulses32 - p), 64'd1);

    for (int i = 0; i < 9; i++) drive32(ca[i], cb[i], cq[i], cr[i]);
    drain();

    // Alternating valid / idle with X operands in the gaps.
    for (int i = 0; i < 5; i++) begin
      drive32(bq_a[i], bq_b[i], bq_q[i], bq_r[i]);
      idle(1);
    end
    drain();

    // Five pairs in flight, reset on the sixth, then three fresh pairs.
    p = pulses32;
    for (int i = 0; i < 5; i++) drive32(32'd50 + 32'(i), 32'd5, 32'd10, 32'(i));
    do_reset(1'b1, 32'd999, 32'd3);
    for (int i = 0; i < 3; i++) drive32(rp_a[i], rp_b[i], rp_q[i], rp_r[i]);
    drain();
    chk("rst_pulses", 64'(pulses32 - p), 64'd3);

    p = pulses32;
    for (int i = 0; i < 100; i++) begin
      av = xs_next();
      bv = xs_next();
      drive32(av, bv, (bv == 0) ? 32'hFFFFFFFF : av / bv, (bv == 0) ? av : av % bv);
    end
    drain();
    chk("stream_pulses", 64'(pulses32 - p), 64'd100);

    p = pulses8;
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        a8 = 8'(ai);
        b8 = 8'(bi);
        drive8(a8, b8, (b8 == 0) ? 8'hFF : a8 / b8, (b8 == 0) ? a8 : a8 % b8);
      end
    end
    drain();
    chk("sweep_pulses", 64'(pulses8 - p), 64'd65536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
